// File: rtl/mio_ram_arbiter_if.sv
// CPU/DMA request ports and RAM-side signals of the MIO data RAM arbiter.
// slave = arbiter view; master = requesters plus RAM model view.
interface mio_ram_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_ack;
  logic [DATA_W-1:0] dma_rdata;

  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data_in;
  logic              ram_we;
  logic [DATA_W-1:0] ram_data_out;
  logic              grant_dma;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata, cpu_stall,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_ack, dma_rdata,
    output ram_addr, ram_data_in, ram_we, grant_dma,
    input  ram_data_out
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata, cpu_stall,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_ack, dma_rdata,
    input  ram_addr, ram_data_in, ram_we, grant_dma,
    output ram_data_out
  );
endinterface

// File: rtl/mio_ram_arbiter.sv
// Shares one synchronous data RAM between CPU and DMA ports (fixed-priority or round-robin).
// Latency: request in IDLE at N -> RAM address at N+1, ack/rdata at N+2, next IDLE at N+3.
// Backpressure: a waiting port sees no ack (CPU also sees cpu_stall); requests sampled only in IDLE.
module mio_ram_arbiter #(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 32,
  parameter int CPU_PRIORITY = 0
) (
  input logic               clk,
  input logic               rst,
  mio_ram_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t            state;
  logic              last_dma;
  logic              acc_we;
  logic              cpu_ack_q;
  logic              dma_ack_q;
  logic [DATA_W-1:0] cpu_hold;
  logic [DATA_W-1:0] dma_hold;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_din_q;
  logic              ram_we_q;
  logic              grant_dma_q;
  logic              pick_dma;

  // DMA wins when alone, or on a tie in round-robin mode when the CPU went last.
  assign pick_dma = bus.dma_req & (~bus.cpu_req | ((CPU_PRIORITY == 0) & ~last_dma));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      last_dma    <= 1'b1;
      acc_we      <= 1'b0;
      cpu_ack_q   <= 1'b0;
      dma_ack_q   <= 1'b0;
      cpu_hold    <= '0;
      dma_hold    <= '0;
      ram_addr_q  <= '0;
      ram_din_q   <= '0;
      ram_we_q    <= 1'b0;
      grant_dma_q <= 1'b0;
    end else begin
      cpu_ack_q <= 1'b0;
      dma_ack_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cpu_req | bus.dma_req) begin
            ram_addr_q  <= pick_dma ? bus.dma_addr  : bus.cpu_addr;
            ram_din_q   <= pick_dma ? bus.dma_wdata : bus.cpu_wdata;
            ram_we_q    <= pick_dma ? bus.dma_we    : bus.cpu_we;
            acc_we      <= pick_dma ? bus.dma_we    : bus.cpu_we;
            grant_dma_q <= pick_dma;
            last_dma    <= pick_dma;
            state       <= ADDR;
          end else begin
            ram_we_q    <= 1'b0;
            grant_dma_q <= 1'b0;
          end
        end
        ADDR: begin
          ram_we_q <= 1'b0;
          if (grant_dma_q) dma_ack_q <= 1'b1;
          else             cpu_ack_q <= 1'b1;
          state <= DATA;
        end
        DATA: begin
          if (!acc_we) begin
            if (grant_dma_q) dma_hold <= bus.ram_data_out;
            else             cpu_hold <= bus.ram_data_out;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read data passes straight through in the ack cycle; otherwise the held value.
  assign bus.cpu_ack     = cpu_ack_q;
  assign bus.dma_ack     = dma_ack_q;
  assign bus.cpu_rdata   = (cpu_ack_q & ~acc_we) ? bus.ram_data_out : cpu_hold;
  assign bus.dma_rdata   = (dma_ack_q & ~acc_we) ? bus.ram_data_out : dma_hold;
  assign bus.cpu_stall   = bus.cpu_req & ~cpu_ack_q;
  assign bus.ram_addr    = ram_addr_q;
  assign bus.ram_data_in = ram_din_q;
  assign bus.ram_we      = ram_we_q;
  assign bus.grant_dma   = grant_dma_q;

endmodule

// File: tb/tb_mio_ram_arbiter.sv
// Directed bench for mio_ram_arbiter: round-robin instance b0 plus a CPU-priority instance b1.
module tb_mio_ram_arbiter;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  logic        ld_en;
  logic [9:0]  ld_addr;
  logic [31:0] ld_dat;
  logic [31:0] mem0 [0:1023];
  logic [31:0] mem1 [0:1023];

  mio_ram_arbiter_if #(.ADDR_W(10), .DATA_W(32)) b0 ();
  mio_ram_arbiter_if #(.ADDR_W(10), .DATA_W(32)) b1 ();

  mio_ram_arbiter #(.ADDR_W(10), .DATA_W(32), .CPU_PRIORITY(0)) u_rr (
    .clk (clk),
    .rst (rst),
    .bus (b0)
  );

  mio_ram_arbiter #(.ADDR_W(10), .DATA_W(32), .CPU_PRIORITY(1)) u_pri (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ld_en) mem0[ld_addr] <= ld_dat;
    else if (b0.ram_we) mem0[b0.ram_addr] <= b0.ram_data_in;
    b0.ram_data_out <= mem0[b0.ram_addr];
  end

  always @(posedge clk) begin
    if (b1.ram_we) mem1[b1.ram_addr] <= b1.ram_data_in;
    b1.ram_data_out <= mem1[b1.ram_addr];
  end

  task clear_inputs;
    b0.cpu_req = 0; b0.cpu_we = 0; b0.cpu_addr = '0; b0.cpu_wdata = '0;
    b0.dma_req = 0; b0.dma_we = 0; b0.dma_addr = '0; b0.dma_wdata = '0;
    b1.cpu_req = 0; b1.cpu_we = 0; b1.cpu_addr = '0; b1.cpu_wdata = '0;
    b1.dma_req = 0; b1.dma_we = 0; b1.dma_addr = '0; b1.dma_wdata = '0;
  endtask

  task do_reset;
    rst = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task test_reset;
    rst = 1'b0;
    @(negedge clk); #1;
    n_cmp++; if (b0.ram_we !== 1'b0) begin n_bad++; $display("FAIL rst_ram_we got %b want 0", b0.ram_we); end
    n_cmp++; if (b0.ram_addr !== 10'd0) begin n_bad++; $display("FAIL rst_ram_addr got %h want 0", b0.ram_addr); end
    n_cmp++; if (b0.ram_data_in !== 32'd0) begin n_bad++; $display("FAIL rst_ram_data_in got %h want 0", b0.ram_data_in); end
    n_cmp++; if (b0.grant_dma !== 1'b0) begin n_bad++; $display("FAIL rst_grant_dma got %b want 0", b0.grant_dma); end
    n_cmp++; if ({b0.cpu_ack, b0.dma_ack} !== 2'b00) begin n_bad++; $display("FAIL rst_acks got %b want 00", {b0.cpu_ack, b0.dma_ack}); end
    n_cmp++; if (b0.cpu_rdata !== 32'd0) begin n_bad++; $display("FAIL rst_cpu_rdata got %h want 0", b0.cpu_rdata); end
    n_cmp++; if (b0.dma_rdata !== 32'd0) begin n_bad++; $display("FAIL rst_dma_rdata got %h want 0", b0.dma_rdata); end
    rst = 1'b1;
    repeat (2) @(negedge clk); #1;
    n_cmp++; if ({b0.ram_we, b0.cpu_ack, b0.dma_ack, b0.grant_dma} !== 4'b0) begin
      n_bad++; $display("FAIL idle_after_rst got %b want 0000", {b0.ram_we, b0.cpu_ack, b0.dma_ack, b0.grant_dma});
    end
  endtask

  task test_tie;
    logic e0c, e0d, e1c;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c == 0) begin
        b0.cpu_req = 1; b0.dma_req = 1; b0.cpu_addr = 10'd1; b0.dma_addr = 10'd2;
        b1.cpu_req = 1; b1.dma_req = 1; b1.cpu_addr = 10'd1; b1.dma_addr = 10'd2;
      end
      #1;
      e0c = (c == 2) || (c == 8);
      e0d = (c == 5) || (c == 11);
      e1c = (c % 3 == 2);
      n_cmp++; if (b0.cpu_ack !== e0c) begin n_bad++; $display("FAIL rr_cpu_ack c=%0d got %b want %b", c, b0.cpu_ack, e0c); end
      n_cmp++; if (b0.dma_ack !== e0d) begin n_bad++; $display("FAIL rr_dma_ack c=%0d got %b want %b", c, b0.dma_ack, e0d); end
      n_cmp++; if (b1.cpu_ack !== e1c) begin n_bad++; $display("FAIL pri_cpu_ack c=%0d got %b want %b", c, b1.cpu_ack, e1c); end
      n_cmp++; if (b1.dma_ack !== 1'b0) begin n_bad++; $display("FAIL pri_dma_ack c=%0d got %b want 0", c, b1.dma_ack); end
      if (c == 4) begin
        n_cmp++; if (b0.ram_addr !== 10'd2 || b0.grant_dma !== 1'b1) begin
          n_bad++; $display("FAIL rr_dma_grant got addr=%h grant=%b want addr=002 grant=1", b0.ram_addr, b0.grant_dma);
        end
      end
      if (c == 11) clear_inputs();
    end
  endtask

  task test_cpu_read;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 0) begin b0.cpu_req = 1; b0.cpu_we = 0; b0.cpu_addr = 10'd5; end
      #1;
      if (c <= 1) begin
        n_cmp++; if (b0.cpu_stall !== 1'b1) begin n_bad++; $display("FAIL rd_stall c=%0d got %b want 1", c, b0.cpu_stall); end
      end
      if (c == 1) begin
        n_cmp++; if (b0.ram_addr !== 10'd5 || b0.ram_we !== 1'b0) begin
          n_bad++; $display("FAIL rd_ram_addr got addr=%h we=%b want addr=005 we=0", b0.ram_addr, b0.ram_we);
        end
      end
      if (c == 2) begin
        n_cmp++; if (b0.cpu_ack !== 1'b1 || b0.cpu_stall !== 1'b0) begin
          n_bad++; $display("FAIL rd_ack got ack=%b stall=%b want ack=1 stall=0", b0.cpu_ack, b0.cpu_stall);
        end
        n_cmp++; if (b0.cpu_rdata !== 32'h1234_5678) begin n_bad++; $display("FAIL rd_data got %h want 12345678", b0.cpu_rdata); end
        b0.cpu_req = 0;
      end
      if (c >= 3) begin
        n_cmp++; if (b0.cpu_rdata !== 32'h1234_5678 || b0.cpu_ack !== 1'b0) begin
          n_bad++; $display("FAIL rd_hold c=%0d got data=%h ack=%b want data=12345678 ack=0", c, b0.cpu_rdata, b0.cpu_ack);
        end
      end
    end
  endtask

  task test_dma_write_cpu_read;
    int we_cnt;
    we_cnt = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 0) begin b0.dma_req = 1; b0.dma_we = 1; b0.dma_addr = 10'h3FF; b0.dma_wdata = 32'hDEAD_BEEF; end
      #1;
      if (b0.ram_we === 1'b1) we_cnt++;
      if (c == 1) begin
        n_cmp++; if (b0.ram_we !== 1'b1 || b0.grant_dma !== 1'b1 || b0.ram_addr !== 10'h3FF || b0.ram_data_in !== 32'hDEAD_BEEF) begin
          n_bad++; $display("FAIL wr_addr got we=%b g=%b a=%h d=%h want we=1 g=1 a=3ff d=deadbeef", b0.ram_we, b0.grant_dma, b0.ram_addr, b0.ram_data_in);
        end
      end
      if (c == 2) begin
        n_cmp++; if (b0.dma_ack !== 1'b1 || b0.cpu_ack !== 1'b0) begin
          n_bad++; $display("FAIL wr_ack got dma=%b cpu=%b want dma=1 cpu=0", b0.dma_ack, b0.cpu_ack);
        end
        n_cmp++; if (b0.cpu_rdata !== 32'h1234_5678) begin n_bad++; $display("FAIL wr_cpu_iso got %h want 12345678", b0.cpu_rdata); end
        b0.dma_req = 0; b0.dma_we = 0;
      end
    end
    n_cmp++; if (we_cnt != 1) begin n_bad++; $display("FAIL wr_we_cycles got %0d want 1", we_cnt); end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 0) begin b0.cpu_req = 1; b0.cpu_we = 0; b0.cpu_addr = 10'h3FF; end
      #1;
      if (c == 2) begin
        n_cmp++; if (b0.cpu_ack !== 1'b1 || b0.cpu_rdata !== 32'hDEAD_BEEF) begin
          n_bad++; $display("FAIL rdback got ack=%b data=%h want ack=1 data=deadbeef", b0.cpu_ack, b0.cpu_rdata);
        end
        b0.cpu_req = 0;
      end
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 0) begin b0.dma_req = 1; b0.dma_we = 0; b0.dma_addr = 10'h3FF; end
      #1;
      if (c == 2) begin
        n_cmp++; if (b0.dma_ack !== 1'b1 || b0.dma_rdata !== 32'hDEAD_BEEF) begin
          n_bad++; $display("FAIL dma_rd got ack=%b data=%h want ack=1 data=deadbeef", b0.dma_ack, b0.dma_rdata);
        end
        b0.dma_req = 0;
      end
    end
  endtask

  task test_back_to_back;
    int  acks;
    logic e;
    acks = 0;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (c == 0) begin b0.cpu_req = 1; b0.cpu_we = 0; b0.cpu_addr = 10'd5; end
      #1;
      e = (c % 3 == 2);
      if (b0.cpu_ack === 1'b1) acks++;
      n_cmp++; if (b0.cpu_ack !== e) begin n_bad++; $display("FAIL b2b_ack c=%0d got %b want %b", c, b0.cpu_ack, e); end
      if (e) begin
        n_cmp++; if (b0.cpu_rdata !== 32'h1234_5678) begin n_bad++; $display("FAIL b2b_data c=%0d got %h want 12345678", c, b0.cpu_rdata); end
      end
      n_cmp++; if (b0.dma_rdata !== 32'hDEAD_BEEF || b0.grant_dma !== 1'b0 || b0.dma_ack !== 1'b0) begin
        n_bad++; $display("FAIL b2b_iso c=%0d got rd=%h g=%b ack=%b want rd=deadbeef g=0 ack=0", c, b0.dma_rdata, b0.grant_dma, b0.dma_ack);
      end
      if (c == 8) b0.cpu_req = 0;
    end
    n_cmp++; if (acks != 3) begin n_bad++; $display("FAIL b2b_count got %0d want 3", acks); end
  endtask

  task test_reset_mid_write;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (c == 0) begin b0.cpu_req = 1; b0.cpu_we = 1; b0.cpu_addr = 10'd7; b0.cpu_wdata = 32'hA5A5_A5A5; end
      #1;
      if (c == 1) begin
        n_cmp++; if (b0.ram_we !== 1'b1) begin n_bad++; $display("FAIL mid_pre_we got %b want 1", b0.ram_we); end
        rst = 1'b0;
        b0.cpu_req = 0; b0.cpu_we = 0;
        #1;
        n_cmp++; if (b0.ram_we !== 1'b0 || b0.ram_addr !== 10'd0 || b0.ram_data_in !== 32'd0) begin
          n_bad++; $display("FAIL mid_rst_ram got we=%b a=%h d=%h want 0", b0.ram_we, b0.ram_addr, b0.ram_data_in);
        end
      end
      if (c == 2) begin
        n_cmp++; if (b0.cpu_ack !== 1'b0) begin n_bad++; $display("FAIL mid_no_ack got %b want 0", b0.cpu_ack); end
        rst = 1'b1;
      end
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      n_cmp++; if ({b0.ram_we, b0.cpu_ack, b0.dma_ack, b0.grant_dma} !== 4'b0 || b0.cpu_rdata !== 32'd0 || b0.dma_rdata !== 32'd0) begin
        n_bad++; $display("FAIL mid_post c=%0d got ctl=%b cr=%h dr=%h want 0", c,
          {b0.ram_we, b0.cpu_ack, b0.dma_ack, b0.grant_dma}, b0.cpu_rdata, b0.dma_rdata);
      end
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 0) begin b0.cpu_req = 1; b0.cpu_we = 0; b0.cpu_addr = 10'd7; end
      #1;
      if (c == 2) begin
        n_cmp++; if (b0.cpu_ack !== 1'b1 || b0.cpu_rdata !== 32'h1111_1111) begin
          n_bad++; $display("FAIL mid_aborted got ack=%b data=%h want ack=1 data=11111111", b0.cpu_ack, b0.cpu_rdata);
        end
        b0.cpu_req = 0;
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b0;
    clear_inputs();
    ld_en = 1'b0; ld_addr = '0; ld_dat = '0;
    @(negedge clk);
    ld_en = 1'b1; ld_addr = 10'd5; ld_dat = 32'h1234_5678;
    @(negedge clk);
    ld_addr = 10'd7; ld_dat = 32'h1111_1111;
    @(negedge clk);
    ld_en = 1'b0;
    test_reset();
    test_tie();
    test_cpu_read();
    test_dma_write_cpu_read();
    test_back_to_back();
    test_reset_mid_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
